// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl -- EX-stage sequencer for the multi-cycle MUL (opcode 8'b00011000).
// Decode leaves RegWrite low for MUL, so this block owns MUL write-back.
// It captures the operands and runs an iterative shift-add multiply, one
// multiplier bit per cycle. While it works it stalls IF/ID/EX. It then
// offers the low XLEN bits of the product on a valid/ready write-port handshake.
//
// Ports:
//   clk, rst_n        clock; synchronous active-low reset
//   mul_req           ID/EX holds a MUL
//   mul_rd/a/b        destination register, multiplicand, multiplier
//   flush             aborts any MUL in flight
//   stall_o           hold IF/ID/EX (combinational)
//   busy              sequencer not idle
//   wb_valid/ready    write-port handshake
//   wb_rd, wb_data    write-back destination and product
//
// Build option: define MUL_EARLY_EXIT_EN to end BUSY as soon as the remaining
// multiplier bits are all zero. When it is undefined, BUSY always lasts XLEN cycles.

module mul_seq_ctrl #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mul_req,
  input  logic [4:0]      mul_rd,
  input  logic [XLEN-1:0] mul_a,
  input  logic [XLEN-1:0] mul_b,
  input  logic            flush,
  output logic            stall_o,
  output logic            busy,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data
);

  localparam int unsigned CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, BUSY, WB} state_t;

  state_t          state, state_next;
  logic [XLEN-1:0] a_q, b_q, acc_q, acc_next, wb_data_q;
  logic [4:0]      rd_q, wb_rd_q;
  logic [CW-1:0]   cnt_q;
  logic            start, last_iter;

  assign start    = (state == IDLE) && mul_req && !flush;
  assign acc_next = b_q[0] ? acc_q + a_q : acc_q;

`ifdef MUL_EARLY_EXIT_EN
  // Stop once the multiplier left after this iteration's shift is zero.
  assign last_iter = (cnt_q == CW'(XLEN-1)) || (b_q[XLEN-1:1] == '0);
`else
  assign last_iter = (cnt_q == CW'(XLEN-1));
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic; flush overrides every other input
  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = IDLE;
    end else begin
      unique case (state)
        IDLE: if (mul_req) state_next = BUSY;
        BUSY: if (last_iter) state_next = (rd_q != '0) ? WB : IDLE;
        WB:   if (wb_ready) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Outputs
  always_comb begin
    busy     = (state != IDLE);
    wb_valid = (state == WB);
    stall_o  = start || (state == BUSY) || ((state == WB) && !wb_ready);
    wb_rd    = wb_rd_q;
    wb_data  = wb_data_q;
  end

  // Datapath. The result registers load only on a real completion, so they
  // stay stable throughout WB. A discarded (rd==0) product never reaches them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
      wb_rd_q   <= '0;
      wb_data_q <= '0;
    end else if (start) begin
      a_q   <= mul_a;
      b_q   <= mul_b;
      rd_q  <= mul_rd;
      acc_q <= '0;
      cnt_q <= '0;
    end else if ((state == BUSY) && !flush) begin
      a_q   <= a_q << 1;
      b_q   <= b_q >> 1;
      acc_q <= acc_next;
      cnt_q <= cnt_q + CW'(1);
      if (last_iter && (rd_q != '0)) begin
        wb_data_q <= acc_next;
        wb_rd_q   <= rd_q;
      end
    end
  end

endmodule
